// File: rtl/mem_dbus_ctrl.sv
// MiniMIPS32 MEM-stage data-bus controller. Issues one SRAM-like bridge transaction per
// load/store, stalls IF..MEM until the response returns, and aligns/extends load data.

package mem_dbus_pkg;
    localparam int ALUOP_W = 8;
    localparam int EXC_W   = 5;

    typedef logic [ALUOP_W-1:0] aluop_t;
    typedef logic [EXC_W-1:0]   exccode_t;

    localparam aluop_t MINIMIPS32_LB  = 8'h90;
    localparam aluop_t MINIMIPS32_LBU = 8'h91;
    localparam aluop_t MINIMIPS32_LH  = 8'h92;
    localparam aluop_t MINIMIPS32_LHU = 8'h93;
    localparam aluop_t MINIMIPS32_LW  = 8'h94;
    localparam aluop_t MINIMIPS32_SB  = 8'h98;
    localparam aluop_t MINIMIPS32_SH  = 8'h99;
    localparam aluop_t MINIMIPS32_SW  = 8'h9A;

    localparam exccode_t EXC_NONE = 5'h10;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_t;
endpackage

module mem_dbus_ctrl
    import mem_dbus_pkg::*;
(
    input  logic             cpu_clk_50M,
    input  logic             cpu_rst_n,
    input  logic [ALUOP_W-1:0] mem_aluop,
    input  logic [31:0]      mem_wd,
    input  logic [31:0]      mem_din,
    input  logic [EXC_W-1:0] mem_exccode,
    input  logic             flush,
    output logic             data_req,
    output logic             data_wr,
    output logic [1:0]       data_size,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_wdata,
    input  logic             data_addr_ok,
    input  logic             data_data_ok,
    input  logic [31:0]      data_rdata,
    output logic             stallreq_mem,
    output logic [31:0]      dm_rdata,
    output logic             dm_valid
);

    state_t      state, state_nxt;
    aluop_t      op_q;
    logic        is_ldst, is_store, access, stall_c;
    logic [1:0]  size_dec;
    logic [31:0] wdata_dec;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        is_ldst   = 1'b0;
        is_store  = 1'b0;
        size_dec  = 2'd2;
        wdata_dec = mem_din;
        case (mem_aluop)
            MINIMIPS32_LB, MINIMIPS32_LBU: begin is_ldst = 1'b1; size_dec = 2'd0; end
            MINIMIPS32_LH, MINIMIPS32_LHU: begin is_ldst = 1'b1; size_dec = 2'd1; end
            MINIMIPS32_LW: is_ldst = 1'b1;
            MINIMIPS32_SB: begin
                is_ldst = 1'b1; is_store = 1'b1; size_dec = 2'd0;
                wdata_dec = {4{mem_din[7:0]}};
            end
            MINIMIPS32_SH: begin
                is_ldst = 1'b1; is_store = 1'b1; size_dec = 2'd1;
                wdata_dec = {2{mem_din[15:0]}};
            end
            MINIMIPS32_SW: begin is_ldst = 1'b1; is_store = 1'b1; end
            default: ;
        endcase
    end

    assign access = is_ldst && (mem_exccode == EXC_NONE) && !flush;

    function automatic logic [31:0] align_load(input aluop_t op, input logic [1:0] a,
                                               input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (op)
            MINIMIPS32_LB:  align_load = {{24{b[7]}}, b};
            MINIMIPS32_LBU: align_load = {24'b0, b};
            MINIMIPS32_LH:  align_load = {{16{h[15]}}, h};
            MINIMIPS32_LHU: align_load = {16'b0, h};
            MINIMIPS32_LW:  align_load = rd;
            default:        align_load = 32'b0;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        dm_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                stall_c = access;
                if (access) state_nxt = S_REQ;
            end
            S_REQ: begin
                stall_c = 1'b1;
                // An accepted request in a flush cycle belongs to a killed instruction: drain it.
                if (data_addr_ok) begin
                    if (flush) state_nxt = data_data_ok ? S_IDLE : S_DRAIN;
                    else       state_nxt = data_data_ok ? S_DONE : S_WAIT;
                end else if (flush) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                if (data_data_ok) state_nxt = flush ? S_IDLE : S_DONE;
                else if (flush)   state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                stall_c = access;
                if (data_data_ok) state_nxt = S_IDLE;
            end
            S_DONE: begin
                dm_valid  = !flush;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The stall is combinational on the MEM instruction, so force it low while reset is held.
    assign stallreq_mem = cpu_rst_n & stall_c;

    // NOTE: only the control/bus flops are reset; there is no memory array in this block.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= 32'b0;
            data_wdata <= 32'b0;
            dm_rdata   <= 32'b0;
            op_q       <= '0;
        end else begin
            if (state == S_IDLE && access) begin
                data_req   <= 1'b1;
                data_wr    <= is_store;
                data_size  <= size_dec;
                data_addr  <= mem_wd;
                data_wdata <= wdata_dec;
                op_q       <= mem_aluop;
            end else if (state == S_REQ && (data_addr_ok || flush)) begin
                data_req <= 1'b0;
            end

            if (state_nxt == S_DONE)  dm_rdata <= align_load(op_q, data_addr[1:0], data_rdata);
            else if (state == S_DONE) dm_rdata <= 32'b0;
        end
    end

endmodule
